// File: rtl/vproc_vcfg.sv
// vproc_vcfg: vector configuration unit for vsetvl/vsetvli/vsetivli.
// Accepts one config request, computes VLMAX, legality and the new vl, then
// updates the vtype/vl state and returns vl to the scalar core.
// Optional build macro: VPROC_VCFG_FAST_EN. When it is defined, the CALC state
// is removed and the result is computed from the request inputs in the accept
// cycle, which gives 1-cycle latency.
module vproc_vcfg #(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned ID_W   = 3
) (
    input  logic                      clk_i,
    input  logic                      sync_rst_ni,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [1:0]                req_vsew_i,
    input  logic [2:0]                req_lmul_i,
    input  logic [1:0]                req_agnostic_i,
    input  logic                      req_vlmax_i,
    input  logic                      req_keep_vl_i,
    input  logic [31:0]               req_avl_i,
    input  logic [ID_W-1:0]           req_id_i,

    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [31:0]               res_vl_o,
    output logic [ID_W-1:0]           res_id_o,

    output logic [1:0]                cfg_vsew_o,
    output logic [2:0]                cfg_lmul_o,
    output logic [1:0]                cfg_agnostic_o,
    output logic [$clog2(VREG_W):0]   cfg_vl_o,
    output logic                      cfg_vill_o
);

    localparam int unsigned VL_W = $clog2(VREG_W) + 1;

    // SEW / LMUL encodings follow the RISC-V vtype field layout
    localparam logic [1:0] VSEW_8       = 2'b00;
    localparam logic [1:0] VSEW_32      = 2'b10;
    localparam logic [1:0] VSEW_INVALID = 2'b11;
    localparam logic [2:0] LMUL_1       = 3'b000;
    localparam logic [2:0] LMUL_INVALID = 3'b100;
    localparam logic [2:0] LMUL_F8      = 3'b101;
    localparam logic [2:0] LMUL_F4      = 3'b110;
    localparam logic [2:0] LMUL_F2      = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              res_valid_q, res_valid_d;
    logic [31:0]       res_vl_q, res_vl_d;
    logic [ID_W-1:0]   res_id_q, res_id_d;
    logic [1:0]        cfg_vsew_q, cfg_vsew_d;
    logic [2:0]        cfg_lmul_q, cfg_lmul_d;
    logic [1:0]        cfg_agn_q, cfg_agn_d;
    logic [VL_W-1:0]   cfg_vl_q, cfg_vl_d;
    logic              cfg_vill_q, cfg_vill_d;

    // Operands feeding the vl computation
    logic [1:0]        src_vsew;
    logic [2:0]        src_lmul;
    logic [1:0]        src_agn;
    logic              src_vlmax;
    logic              src_keep;
    logic [31:0]       src_avl;
    logic [ID_W-1:0]   src_id;

    logic              accept;
    logic              update;

    assign accept = (state_q == ST_IDLE) && ready_q && req_valid_i;

`ifdef VPROC_VCFG_FAST_EN
    // Fast build: compute straight from the request inputs in the accept cycle
    assign src_vsew  = req_vsew_i;
    assign src_lmul  = req_lmul_i;
    assign src_agn   = req_agnostic_i;
    assign src_vlmax = req_vlmax_i;
    assign src_keep  = req_keep_vl_i;
    assign src_avl   = req_avl_i;
    assign src_id    = req_id_i;
    assign update    = accept;
`else
    logic [1:0]        req_vsew_q, req_vsew_d;
    logic [2:0]        req_lmul_q, req_lmul_d;
    logic [1:0]        req_agn_q, req_agn_d;
    logic              req_vlmax_q, req_vlmax_d;
    logic              req_keep_q, req_keep_d;
    logic [31:0]       req_avl_q, req_avl_d;
    logic [ID_W-1:0]   req_id_q, req_id_d;

    // Capture the request on accept so later input changes cannot leak in
    always_comb begin
        req_vsew_d  = req_vsew_q;
        req_lmul_d  = req_lmul_q;
        req_agn_d   = req_agn_q;
        req_vlmax_d = req_vlmax_q;
        req_keep_d  = req_keep_q;
        req_avl_d   = req_avl_q;
        req_id_d    = req_id_q;
        if (accept) begin
            req_vsew_d  = req_vsew_i;
            req_lmul_d  = req_lmul_i;
            req_agn_d   = req_agnostic_i;
            req_vlmax_d = req_vlmax_i;
            req_keep_d  = req_keep_vl_i;
            req_avl_d   = req_avl_i;
            req_id_d    = req_id_i;
        end
    end

    // Request holding registers (no reset needed: only read in CALC)
    always_ff @(posedge clk_i) begin
        req_vsew_q  <= req_vsew_d;
        req_lmul_q  <= req_lmul_d;
        req_agn_q   <= req_agn_d;
        req_vlmax_q <= req_vlmax_d;
        req_keep_q  <= req_keep_d;
        req_avl_q   <= req_avl_d;
        req_id_q    <= req_id_d;
    end

    assign src_vsew  = req_vsew_q;
    assign src_lmul  = req_lmul_q;
    assign src_agn   = req_agn_q;
    assign src_vlmax = req_vlmax_q;
    assign src_keep  = req_keep_q;
    assign src_avl   = req_avl_q;
    assign src_id    = req_id_q;
    assign update    = (state_q == ST_CALC);
`endif

    logic [31:0] vreg_full;
    logic [3:0]  sew_shift;
    logic [31:0] vlmax;
    logic [31:0] cur_vl;
    logic        illegal;
    logic [31:0] vl_new;

    assign vreg_full = 32'(VREG_W);
    assign sew_shift = 4'd3 + {2'b00, src_vsew};
    assign cur_vl    = {{(32-VL_W){1'b0}}, cfg_vl_q};

    // VLMAX, legality and the resulting vl
    always_comb begin
        if (!src_lmul[2]) begin
            vlmax = (vreg_full << src_lmul[1:0]) >> sew_shift;
        end else begin
            // 3'b111 -> F2 (k=1), 3'b110 -> F4 (k=2), 3'b101 -> F8 (k=3)
            vlmax = (vreg_full >> sew_shift) >> (4'd8 - {1'b0, src_lmul});
        end

        illegal = (src_vsew == VSEW_INVALID) ||
                  (src_lmul == LMUL_INVALID) ||
                  (src_lmul == LMUL_F8) ||
                  ((src_lmul == LMUL_F4) && (src_vsew != VSEW_8)) ||
                  ((src_lmul == LMUL_F2) && (src_vsew == VSEW_32));

        if (src_vlmax) begin
            vl_new = vlmax;
        end else if (src_keep) begin
            vl_new = cur_vl;
            if (cur_vl > vlmax) begin
                illegal = 1'b1;
            end
        end else begin
            vl_new = (src_avl < vlmax) ? src_avl : vlmax;
        end

        if (illegal) begin
            vl_new = 32'd0;
        end
    end

    // FSM next state, registered outputs and cfg state update
    always_comb begin
        state_d     = state_q;
        res_vl_d    = res_vl_q;
        res_id_d    = res_id_q;
        cfg_vsew_d  = cfg_vsew_q;
        cfg_lmul_d  = cfg_lmul_q;
        cfg_agn_d   = cfg_agn_q;
        cfg_vl_d    = cfg_vl_q;
        cfg_vill_d  = cfg_vill_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef VPROC_VCFG_FAST_EN
                    state_d = ST_RESP;
`else
                    state_d = ST_CALC;
`endif
                end
            end
            ST_CALC: state_d = ST_RESP;
            ST_RESP: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (update) begin
            res_vl_d = vl_new;
            res_id_d = src_id;
            if (illegal) begin
                cfg_vsew_d = VSEW_8;
                cfg_lmul_d = LMUL_1;
                cfg_agn_d  = 2'b00;
                cfg_vl_d   = '0;
                cfg_vill_d = 1'b1;
            end else begin
                cfg_vsew_d = src_vsew;
                cfg_lmul_d = src_lmul;
                cfg_agn_d  = src_agn;
                cfg_vl_d   = vl_new[VL_W-1:0];
                cfg_vill_d = 1'b0;
            end
        end

        ready_d     = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_RESP);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_vl_q    <= 32'd0;
            res_id_q    <= '0;
            cfg_vsew_q  <= VSEW_8;
            cfg_lmul_q  <= LMUL_1;
            cfg_agn_q   <= 2'b00;
            cfg_vl_q    <= '0;
            cfg_vill_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
            res_vl_q    <= res_vl_d;
            res_id_q    <= res_id_d;
            cfg_vsew_q  <= cfg_vsew_d;
            cfg_lmul_q  <= cfg_lmul_d;
            cfg_agn_q   <= cfg_agn_d;
            cfg_vl_q    <= cfg_vl_d;
            cfg_vill_q  <= cfg_vill_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign res_valid_o    = res_valid_q;
    assign res_vl_o       = res_vl_q;
    assign res_id_o       = res_id_q;
    assign cfg_vsew_o     = cfg_vsew_q;
    assign cfg_lmul_o     = cfg_lmul_q;
    assign cfg_agnostic_o = cfg_agn_q;
    assign cfg_vl_o       = cfg_vl_q;
    assign cfg_vill_o     = cfg_vill_q;

endmodule

// File: doc/vproc_vcfg.md
VPROC_VCFG -- requirements
Module: vproc_vcfg

Interface
REQ-001 SHALL provide parameter VREG_W, default 128, meaning vector register width in bits (power of two, >=64).
REQ-002 SHALL provide parameter ID_W, default 3, meaning instruction-ID width.
REQ-003 SHALL provide clk_i  input  1  clock; one clock, all state on the rising edge.
REQ-004 SHALL provide sync_rst_ni  input  1  reset, synchronous and active-low.
REQ-005 SHALL provide req_valid_i  input  1  a config instruction (vsetvl/vsetvli/vsetivli) is offered.
REQ-006 SHALL provide req_ready_o  output  1  the block accepts the request.
REQ-007 SHALL provide req_vsew_i  input  2  requested SEW (cfg_vsew).
REQ-008 SHALL provide req_lmul_i  input  3  requested LMUL (cfg_lmul).
REQ-009 SHALL provide req_agnostic_i  input  2  vta/vma bits.
REQ-010 SHALL provide req_vlmax_i  input  1  set vl to VLMAX.
REQ-011 SHALL provide req_keep_vl_i  input  1  retain the current vl.
REQ-012 SHALL provide req_avl_i  input  32  application vector length.
REQ-013 SHALL provide req_id_i  input  ID_W  instruction ID.
REQ-014 SHALL provide res_valid_o  output  1  vl result is available for the scalar core.
REQ-015 SHALL provide res_ready_i  input  1  the core consumes the result.
REQ-016 SHALL provide res_vl_o  output  32  new vl, zero-extended.
REQ-017 SHALL provide res_id_o  output  ID_W  ID of the completed request.
REQ-018 SHALL provide cfg_vsew_o  output  2  current SEW state.
REQ-019 SHALL provide cfg_lmul_o  output  3  current LMUL state.
REQ-020 SHALL provide cfg_agnostic_o  output  2  current vta/vma state.
REQ-021 SHALL provide cfg_vl_o  output  VL_W  current vl, where VL_W = clog2(VREG_W)+1.
REQ-022 SHALL provide cfg_vill_o  output  1  illegal configuration flag.

Function
REQ-023 SHALL implement FSM states IDLE, CALC and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-024 Transitions: IDLE->CALC on req_valid_i; CALC->RESP unconditionally; RESP->IDLE on res_ready_i; otherwise the state SHALL be held.
REQ-025 On accept, all req_* fields SHALL be registered, and later input changes SHALL be ignored.
REQ-026 Integer VLMAX SHALL be (VREG_W<<lmul)>>(3+vsew); for fractional LMUL F2/F4/F8, VLMAX SHALL be (VREG_W>>(3+vsew))>>k with k=1/2/3.
REQ-027 The configuration SHALL be illegal when vsew=VSEW_INVALID, lmul=LMUL_INVALID, lmul=LMUL_F8, lmul=LMUL_F4 with vsew!=VSEW_8, or lmul=LMUL_F2 with vsew=VSEW_32.
REQ-028 vl SHALL be VLMAX if req_vlmax_i; else current vl if req_keep_vl_i; else min(req_avl_i, VLMAX), with the comparison done at full 32 bits.
REQ-029 req_vlmax_i SHALL take priority over req_keep_vl_i.
REQ-030 With req_keep_vl_i, if current vl > new VLMAX, the configuration SHALL be illegal.
REQ-031 An illegal configuration SHALL set vill=1, vl=0, vsew=VSEW_8, lmul=LMUL_1, agnostic=0; a legal one SHALL set vill=0 and load the new fields.
REQ-032 cfg_* registers SHALL update on the CALC->RESP edge only.
REQ-033 res_vl_o and res_id_o SHALL be registered on the same edge and held stable while res_valid_o=1 and res_ready_i=0.
REQ-034 res_valid_o SHALL be 1 exactly in RESP.
REQ-035 Latency from the accept edge to res_valid_o=1 SHALL be 2 cycles.
REQ-036 Back-to-back requests SHALL reach a throughput of one per 3 cycles.
REQ-037 AVL=0 SHALL give vl=0 with vill=0 if the configuration is legal.

Reset
REQ-038 While sync_rst_ni=0 at a clock edge: state=IDLE, res_valid_o=0, res_vl_o=0, res_id_o=0, cfg_vill_o=1, cfg_vl_o=0, cfg_vsew_o=VSEW_8, cfg_lmul_o=LMUL_1, cfg_agnostic_o=0.
REQ-039 Reset in CALC or RESP SHALL discard the in-flight request with no cfg update.
REQ-040 req_ready_o SHALL be 0 during reset.

Configuration
REQ-041 Macro VPROC_VCFG_FAST_EN, when defined, SHALL remove CALC (IDLE->RESP on accept), with computation done combinationally from the request inputs, 1-cycle latency, and one request per 2 cycles.
REQ-042 Without VPROC_VCFG_FAST_EN the block SHALL behave as described in REQ-023 to REQ-036.
REQ-043 Functional results SHALL be identical in both builds.

Verification (VREG_W=128)
REQ-044 vsew=VSEW_32, lmul=LMUL_1, avl=10 -> vl=4, vill=0, res_valid_o 2 cycles after accept.
REQ-045 vsew=VSEW_8, lmul=LMUL_8, req_vlmax_i=1 -> vl=128, cfg_vl_o=128.
REQ-046 vsew=VSEW_16, lmul=LMUL_F8, avl=5 -> vill=1, vl=0, res_vl_o=0, cfg_vsew_o=VSEW_8.
REQ-047 vl=4, then keep_vl with vsew=VSEW_8, lmul=LMUL_1 -> vl=4; then keep_vl with vsew=VSEW_16, lmul=LMUL_F2 (VLMAX=4) -> vl=4; then keep_vl with vsew=VSEW_16, lmul=LMUL_F4 -> illegal per REQ-027, vill=1.
REQ-048 res_ready_i=0 for 3 cycles in RESP -> res_valid_o=1 and res_vl_o/res_id_o stable, req_ready_o=0; accepted on the 4th cycle.
REQ-049 sync_rst_ni=0 for one cycle while in CALC -> next cycle state=IDLE, res_valid_o=0, cfg_vill_o=1, no response is ever produced.
